// File: rtl/pipelined_prefix_adder.sv
// ---------------------------------------------------------------------------
// pipelined_prefix_adder
//
// Pipelined Kogge-Stone adder/subtractor with a valid/ready handshake on both
// sides. Rank 0 captures the per-bit generate/propagate terms and the
// effective carry-in. The carry-in is folded into the bit-0 generate term.
// Ranks 1..LEVELS each register one prefix level, with spans 1, 2, 4, ...
// The sum is formed combinationally from the last rank. Latency is LEVELS+1
// cycles, and one operation can be accepted per cycle.
//
// Parameters
//   WIDTH   operand/sum width, 2..64 (non-power-of-two allowed)
//   LEVELS  derived as $clog2(WIDTH); a localparam, not overridable
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   in_valid   operand set presented
//   in_ready   block can accept this cycle (low only while the output stalls)
//   in_a/in_b  operands
//   in_cin     carry-in, ignored in subtract mode
//   in_sub     0: A+B+cin   1: A-B (computed as A + ~B + 1)
//   out_valid  result available
//   out_ready  consumer accepts result
//   out_sum    result
//   out_cout   carry-out (add) / no-borrow flag (sub)
//   out_ovf    signed overflow; present only when PFX_ADD_OVF_EN is defined
//
// Optional feature macro: PFX_ADD_OVF_EN
// ---------------------------------------------------------------------------
module pipelined_prefix_adder #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout
`ifdef PFX_ADD_OVF_EN
  ,
  output logic             out_ovf
`endif
);

  localparam int LEVELS = $clog2(WIDTH);

  // Rank s holds the state after s prefix levels have been applied.
  logic [LEVELS:0] valid_q;
  logic [LEVELS:0] cin_q;                // effective carry-in, needed for sum bit 0
  logic [WIDTH-1:0] g_q  [0:LEVELS];     // group generate
  logic [WIDTH-1:0] pg_q [0:LEVELS];     // group propagate
  logic [WIDTH-1:0] p_q  [0:LEVELS];     // original per-bit propagate, kept for the sum

  logic [WIDTH-1:0] g_nxt  [1:LEVELS];
  logic [WIDTH-1:0] pg_nxt [1:LEVELS];

  logic             stall;
  logic             accept;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;
  logic [WIDTH-1:0] p0;
  logic [WIDTH-1:0] g0;
  logic [WIDTH-1:0] carries;

  // Every rank moves together, so a stalled output freezes the whole pipe.
  // Bubbles are never squeezed out.
  assign stall    = valid_q[LEVELS] && !out_ready;
  assign in_ready = !stall;
  assign accept   = in_valid && in_ready;

  // Rank-0 terms. Subtract mode is A + ~B + 1, so in_cin is overridden.
  // Folding cin into g0[0] makes prefix G[i] the carry out of bit i.
  always_comb begin
    // NOTE: every always_comb output gets a full default first, so no path
    // can leave a value unassigned and infer a latch.
    b_eff   = in_sub ? ~in_b : in_b;
    cin_eff = in_sub | in_cin;
    p0      = in_a ^ b_eff;
    g0      = in_a & b_eff;
    g0[0]   = g0[0] | (p0[0] & cin_eff);
  end

  // Kogge-Stone levels. Bits below the span already hold their final prefix
  // and pass through unchanged.
  always_comb begin
    for (int s = 1; s <= LEVELS; s++) begin
      g_nxt[s]  = g_q[s-1];
      pg_nxt[s] = pg_q[s-1];
      for (int i = (1 << (s - 1)); i < WIDTH; i++) begin
        g_nxt[s][i]  = g_q[s-1][i] | (pg_q[s-1][i] & g_q[s-1][i - (1 << (s - 1))]);
        pg_nxt[s][i] = pg_q[s-1][i] & pg_q[s-1][i - (1 << (s - 1))];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      cin_q   <= '0;
      // NOTE: the datapath ranks are reset too, not just the valid bits,
      // because out_sum/out_cout are driven combinationally from the last
      // rank and must read zero after reset.
      for (int s = 0; s <= LEVELS; s++) begin
        g_q[s]  <= '0;
        pg_q[s] <= '0;
        p_q[s]  <= '0;
      end
    end else if (!stall) begin
      // NOTE: non-blocking assignments, so each rank samples the previous
      // rank's old value and the shift does not collapse in one edge.
      valid_q <= {valid_q[LEVELS-1:0], accept};
      // Data moves only behind a valid slot, so the outputs hold their last
      // result while bubbles pass through.
      if (accept) begin
        g_q[0]   <= g0;
        pg_q[0]  <= p0;
        p_q[0]   <= p0;
        cin_q[0] <= cin_eff;
      end
      for (int s = 1; s <= LEVELS; s++) begin
        if (valid_q[s-1]) begin
          g_q[s]   <= g_nxt[s];
          pg_q[s]  <= pg_nxt[s];
          p_q[s]   <= p_q[s-1];
          cin_q[s] <= cin_q[s-1];
        end
      end
    end
  end

  // The carry into bit i is the prefix generate of bit i-1. Bit 0 uses cin.
  assign carries   = {g_q[LEVELS][WIDTH-2:0], cin_q[LEVELS]};
  assign out_valid = valid_q[LEVELS];
  assign out_sum   = p_q[LEVELS] ^ carries;
  assign out_cout  = g_q[LEVELS][WIDTH-1];

`ifdef PFX_ADD_OVF_EN
  // Signed overflow: the carry into the MSB differs from the carry out of it.
  assign out_ovf = g_q[LEVELS][WIDTH-1] ^ carries[WIDTH-1];
`endif

endmodule

// File: tb/tb_pipelined_prefix_adder.sv
// ---------------------------------------------------------------------------
// tb_pipelined_prefix_adder
//
// Scoreboard bench for pipelined_prefix_adder. Three instances are used:
// WIDTH=32, which gets directed vectors, a stall, and a reset flush, plus
// WIDTH=8 and WIDTH=12, which get random streams. The stimulus side pushes
// the expected result when an operand is accepted. A monitor per instance
// pops and compares on every output transfer, and also checks the latency.
// ---------------------------------------------------------------------------
module tb_pipelined_prefix_adder;

  localparam int LAT32 = 6;
  localparam int LAT8  = 4;
  localparam int LAT12 = 5;

  typedef struct {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
    int          acc;
    bit          chk_lat;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   nchk = 0;
  int   nerr = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- WIDTH=32 instance ----------------
  logic        in_valid, in_ready, in_cin, in_sub, out_valid, out_ready, out_cout;
  logic [31:0] in_a, in_b, out_sum;
`ifdef PFX_ADD_OVF_EN
  logic        out_ovf;
`endif

  pipelined_prefix_adder #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_cout(out_cout)
`ifdef PFX_ADD_OVF_EN
    , .out_ovf(out_ovf)
`endif
  );

  // ---------------- WIDTH=8 instance ----------------
  logic       in_valid8, in_ready8, in_cin8, in_sub8, out_valid8, out_ready8, out_cout8;
  logic [7:0] in_a8, in_b8, out_sum8;
`ifdef PFX_ADD_OVF_EN
  logic       out_ovf8;
`endif

  pipelined_prefix_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
    .in_a(in_a8), .in_b(in_b8), .in_cin(in_cin8), .in_sub(in_sub8),
    .out_valid(out_valid8), .out_ready(out_ready8), .out_sum(out_sum8),
    .out_cout(out_cout8)
`ifdef PFX_ADD_OVF_EN
    , .out_ovf(out_ovf8)
`endif
  );

  // ---------------- WIDTH=12 instance ----------------
  logic        in_valid12, in_ready12, in_cin12, in_sub12, out_valid12, out_ready12, out_cout12;
  logic [11:0] in_a12, in_b12, out_sum12;
`ifdef PFX_ADD_OVF_EN
  logic        out_ovf12;
`endif

  pipelined_prefix_adder #(.WIDTH(12)) dut12 (
    .clk(clk), .reset(reset), .in_valid(in_valid12), .in_ready(in_ready12),
    .in_a(in_a12), .in_b(in_b12), .in_cin(in_cin12), .in_sub(in_sub12),
    .out_valid(out_valid12), .out_ready(out_ready12), .out_sum(out_sum12),
    .out_cout(out_cout12)
`ifdef PFX_ADD_OVF_EN
    , .out_ovf(out_ovf12)
`endif
  );

  // Expected values that go with the operand currently driven on dut32.
  logic [31:0] exp_sum;
  logic        exp_cout, exp_ovf;
  bit          lat_en;

  exp_t q32[$];
  exp_t q8[$];
  exp_t q12[$];
  exp_t e32, e8, e12;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Plain arithmetic reference: returns {ovf, cout, sum}.
  function automatic logic [65:0] model(input int w, input logic [63:0] a, input logic [63:0] b,
                                        input logic cin, input logic sub);
    logic [63:0] mask, be, s;
    logic [64:0] full;
    logic        ci, co, ov;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    be   = sub ? (~b & mask) : (b & mask);
    ci   = sub | cin;
    full = {1'b0, a & mask} + {1'b0, be} + {64'd0, ci};
    s    = full[63:0] & mask;
    co   = full[w];
    ov   = (a[w-1] == be[w-1]) && (s[w-1] != a[w-1]);
    return {ov, co, s};
  endfunction

  // ---------------- scoreboards / monitors ----------------
  always @(negedge clk) begin
    if (!reset) begin
      if (in_valid && in_ready) begin
        e32.sum = {32'd0, exp_sum}; e32.cout = exp_cout; e32.ovf = exp_ovf;
        e32.acc = cyc; e32.chk_lat = lat_en;
        q32.push_back(e32);
      end
      if (out_valid && out_ready) begin
        if (q32.size() == 0) check("spurious32", {63'd0, out_valid}, 64'd0);
        else begin
          e32 = q32.pop_front();
          check("sum32", {32'd0, out_sum}, e32.sum);
          check("cout32", {63'd0, out_cout}, {63'd0, e32.cout});
`ifdef PFX_ADD_OVF_EN
          check("ovf32", {63'd0, out_ovf}, {63'd0, e32.ovf});
`endif
          if (e32.chk_lat) check("lat32", 64'(cyc - e32.acc), 64'(LAT32));
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [65:0] r;
    if (!reset) begin
      if (in_valid8 && in_ready8) begin
        r = model(8, {56'd0, in_a8}, {56'd0, in_b8}, in_cin8, in_sub8);
        e8.sum = r[63:0]; e8.cout = r[64]; e8.ovf = r[65]; e8.acc = cyc; e8.chk_lat = 1'b1;
        q8.push_back(e8);
      end
      if (out_valid8 && out_ready8) begin
        if (q8.size() == 0) check("spurious8", {63'd0, out_valid8}, 64'd0);
        else begin
          e8 = q8.pop_front();
          check("sum8", {56'd0, out_sum8}, e8.sum);
          check("cout8", {63'd0, out_cout8}, {63'd0, e8.cout});
`ifdef PFX_ADD_OVF_EN
          check("ovf8", {63'd0, out_ovf8}, {63'd0, e8.ovf});
`endif
          check("lat8", 64'(cyc - e8.acc), 64'(LAT8));
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [65:0] r;
    if (!reset) begin
      if (in_valid12 && in_ready12) begin
        r = model(12, {52'd0, in_a12}, {52'd0, in_b12}, in_cin12, in_sub12);
        e12.sum = r[63:0]; e12.cout = r[64]; e12.ovf = r[65]; e12.acc = cyc; e12.chk_lat = 1'b1;
        q12.push_back(e12);
      end
      if (out_valid12 && out_ready12) begin
        if (q12.size() == 0) check("spurious12", {63'd0, out_valid12}, 64'd0);
        else begin
          e12 = q12.pop_front();
          check("sum12", {52'd0, out_sum12}, e12.sum);
          check("cout12", {63'd0, out_cout12}, {63'd0, e12.cout});
`ifdef PFX_ADD_OVF_EN
          check("ovf12", {63'd0, out_ovf12}, {63'd0, e12.ovf});
`endif
          check("lat12", 64'(cyc - e12.acc), 64'(LAT12));
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  // Called at posedge+1; returns at posedge+1 after the operand is taken.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic cin,
                       input logic sub, input logic [31:0] es, input logic ec,
                       input logic eo, input bit lat);
    int n;
    in_a = a; in_b = b; in_cin = cin; in_sub = sub;
    exp_sum = es; exp_cout = ec; exp_ovf = eo; lat_en = lat;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("accept_timeout", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic issue_model(input logic [31:0] a, input logic [31:0] b,
                             input logic cin, input logic sub, input bit lat);
    logic [65:0] r;
    r = model(32, {32'd0, a}, {32'd0, b}, cin, sub);
    issue(a, b, cin, sub, r[31:0], r[64], r[65], lat);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q32.size() + q8.size() + q12.size()) != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain", 64'(q32.size() + q8.size() + q12.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] rnd;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0;
    exp_sum = '0; exp_cout = 1'b0; exp_ovf = 1'b0; lat_en = 1'b0;
    in_valid8 = 1'b0; out_ready8 = 1'b1; in_a8 = '0; in_b8 = '0; in_cin8 = 1'b0; in_sub8 = 1'b0;
    in_valid12 = 1'b0; out_ready12 = 1'b1; in_a12 = '0; in_b12 = '0; in_cin12 = 1'b0; in_sub12 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state, in the cycle after reset is released.
    @(negedge clk);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_sum", {32'd0, out_sum}, 64'd0);
    check("rst_out_cout", {63'd0, out_cout}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
`ifdef PFX_ADD_OVF_EN
    check("rst_out_ovf", {63'd0, out_ovf}, 64'd0);
`endif
    @(posedge clk);
    #1;

    // Directed vectors with hand-computed results, issued back to back.
    //      A             B             cin   sub   sum           cout  ovf
    issue(32'hD5554554, 32'hAAAAAAAA, 1'b0, 1'b0, 32'h7FFFEFFE, 1'b1, 1'b1, 1'b1);
    issue(32'h55555555, 32'hAAAAAAAA, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1);
    issue(32'h55555555, 32'hAAAAAAAA, 1'b0, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1);
    issue(32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b1);
    issue(32'h00000007, 32'h00000005, 1'b0, 1'b1, 32'h00000002, 1'b1, 1'b0, 1'b1);
    issue(32'h00000007, 32'h00000005, 1'b1, 1'b1, 32'h00000002, 1'b1, 1'b0, 1'b1);
    issue(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b1);
    issue(32'h12345678, 32'h12345678, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1);
    issue(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1);
    issue(32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b1);
    issue(32'h00000000, 32'h00000001, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1);
    drain();

    // Ten back-to-back mixed-mode operations with a 3-cycle output stall.
    fork
      begin
        for (int i = 0; i < 10; i++)
          issue_model(32'(i) * 32'h13579BDF, 32'hF0F00F0F ^ 32'(i << 4),
                      1'(i % 2), 1'(i % 3 == 0), 1'b0);
      end
      begin
        int n;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 40) begin
          @(negedge clk);
          n++;
        end
        check("stall_first_valid", {63'd0, out_valid}, 64'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          check("stall_out_valid", {63'd0, out_valid}, 64'd1);
          check("stall_in_ready", {63'd0, in_ready}, 64'd0);
          if (q32.size() != 0) check("stall_sum_held", {32'd0, out_sum}, q32[0].sum);
          else check("stall_queue", 64'(q32.size()), 64'd1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with four operations in flight: all of them must vanish.
    issue(32'h00000001, 32'h00000001, 1'b0, 1'b0, 32'h00000002, 1'b0, 1'b0, 1'b1);
    issue(32'h00000002, 32'h00000002, 1'b0, 1'b0, 32'h00000004, 1'b0, 1'b0, 1'b1);
    issue(32'h00000003, 32'h00000003, 1'b0, 1'b0, 32'h00000006, 1'b0, 1'b0, 1'b1);
    issue(32'h00000004, 32'h00000004, 1'b0, 1'b0, 32'h00000008, 1'b0, 1'b0, 1'b1);
    reset = 1'b1;
    q32.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("flush_out_valid", {63'd0, out_valid}, 64'd0);
    check("flush_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1;
    issue(32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 32'h00010000, 1'b0, 1'b0, 1'b1);
    repeat (12) @(negedge clk);
    drain();

    // Random streams on the narrow instances, output always ready.
    in_valid8 = 1'b1;
    in_valid12 = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      rnd = $urandom; in_a8  = rnd[7:0];  in_b8  = rnd[15:8];
      in_cin8 = rnd[16]; in_sub8 = rnd[17];
      rnd = $urandom; in_a12 = rnd[11:0]; in_b12 = rnd[23:12];
      in_cin12 = rnd[24]; in_sub12 = rnd[25];
      @(posedge clk);
      #1;
    end
    in_valid8 = 1'b0;
    in_valid12 = 1'b0;
    drain();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
